// File: rtl/csel_adder_pipe_pkg.sv
// Shared arithmetic constants for the pipelined carry-select adder.
package csel_adder_pipe_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/csel_adder_pipe_block.sv
// One carry-select block: two ripple chains (carry-in 0 and 1) and a select
// on the real carry-in; also reports the carry into the block MSB.
module csel_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout,
    output logic           c_msb_in
);

    logic [BLK-1:0] s0;
    logic [BLK-1:0] s1;
    logic [BLK:0]   c0;
    logic [BLK:0]   c1;

    always_comb begin
        s0    = '0;
        s1    = '0;
        c0    = '0;
        c1    = '0;
        c0[0] = 1'b0;
        c1[0] = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            s0[i]   = a[i] ^ b[i] ^ c0[i];
            c0[i+1] = (a[i] & b[i]) | (a[i] & c0[i]) | (b[i] & c0[i]);
            s1[i]   = a[i] ^ b[i] ^ c1[i];
            c1[i+1] = (a[i] & b[i]) | (a[i] & c1[i]) | (b[i] & c1[i]);
        end
    end

    assign sum      = cin ? s1 : s0;
    assign cout     = cin ? c1[BLK] : c0[BLK];
    assign c_msb_in = cin ? c1[BLK-1] : c0[BLK-1];

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined WIDTH-bit add/sub: one carry-select block resolved per stage,
// registered carry between stages, valid/ready handshake with global stall.
module csel_adder_pipe
    import csel_adder_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NBLK = WIDTH / BLK;

    // Handshake: a bundle is taken on a rising edge with in_valid & in_ready;
    // a result retires on a rising edge with out_valid & out_ready. The only
    // stall source is an unaccepted result (out_valid & ~out_ready); while it
    // lasts every register holds and in_ready is low. Bubbles never stall.
    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    logic             st_vld [NBLK];
    logic [WIDTH-1:0] st_a   [NBLK];
    logic [WIDTH-1:0] st_b   [NBLK];
    logic [WIDTH-1:0] st_sum [NBLK];
    logic             st_c   [NBLK];

    logic [BLK-1:0]   blk_sum  [NBLK];
    logic             blk_cout [NBLK];
    logic             blk_cmsb [NBLK];
    logic [WIDTH-1:0] merged   [NBLK];

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        csel_block #(.BLK(BLK)) u_blk (
            .a        (st_a[k][k*BLK +: BLK]),
            .b        (st_b[k][k*BLK +: BLK]),
            .cin      (st_c[k]),
            .sum      (blk_sum[k]),
            .cout     (blk_cout[k]),
            .c_msb_in (blk_cmsb[k])
        );
        // Bits at and above k*BLK are still zero in stage k.
        assign merged[k] = st_sum[k] | (WIDTH'(blk_sum[k]) << (k*BLK));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBLK; k++) begin
                st_vld[k] <= 1'b0;
                st_a[k]   <= '0;
                st_b[k]   <= '0;
                st_sum[k] <= '0;
                st_c[k]   <= 1'b0;
            end
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            st_vld[0] <= in_valid;
            // Data registers only load with a valid bundle so idle X never enters.
            if (in_valid) begin
                st_a[0]   <= in_a;
                st_b[0]   <= (in_sub == OP_SUB) ? ~in_b : in_b;
                st_c[0]   <= (in_sub == OP_SUB) ? 1'b1 : in_cin;
                st_sum[0] <= '0;
            end
            for (int k = 1; k < NBLK; k++) begin
                st_vld[k] <= st_vld[k-1];
                if (st_vld[k-1]) begin
                    st_a[k]   <= st_a[k-1];
                    st_b[k]   <= st_b[k-1];
                    st_c[k]   <= blk_cout[k-1];
                    st_sum[k] <= merged[k-1];
                end
            end
            out_valid <= st_vld[NBLK-1];
            if (st_vld[NBLK-1]) begin
                out_sum  <= merged[NBLK-1];
                out_cout <= blk_cout[NBLK-1];
                out_ovf  <= blk_cmsb[NBLK-1] ^ blk_cout[NBLK-1];
            end
        end
    end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Self-checking bench for csel_adder_pipe (WIDTH=16, BLK=4).
module tb_csel_adder_pipe;

    localparam int WIDTH = 16;
    localparam int BLK   = 4;
    localparam int NBLK  = WIDTH / BLK;
    localparam int W     = WIDTH + 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           got_t[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csel_adder_pipe #(.WIDTH(WIDTH), .BLK(BLK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // reference model: {cout, ovf, sum}
    function automatic logic [W-1:0] model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                           logic cin, logic sub);
        logic [WIDTH-1:0] eb;
        logic [WIDTH:0]   full;
        logic             ovf;
        eb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, eb} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
        ovf  = (a[WIDTH-1] == eb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {full[WIDTH], ovf, full[WIDTH-1:0]};
    endfunction

    // scoreboard feed: inputs and outputs are stable at the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
            if (out_valid && out_ready) begin
                got_q.push_back({out_cout, out_ovf, out_sum});
                got_t.push_back(cyc);
            end
        end
    end

    // driver tasks
    task automatic drive_idle();
        in_valid = 1'b0;
        in_a     = 'x;
        in_b     = 'x;
        in_cin   = 1'b0;
        in_sub   = 1'b0;
    endtask

    task automatic drive_rand();
        in_valid = 1'b1;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_cin   = 1'($urandom_range(0, 1));
        in_sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_sum !== '0) begin failures++; $display("FAIL reset_sum got=%h exp=0000", out_sum); end
        checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", out_cout); end
        checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", out_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [WIDTH-1:0] tb [5] = '{16'h0FFF, 16'h0000, 16'h0001, 16'h0007, 16'h0001};
        logic             tc [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic             tsb[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [WIDTH-1:0] es [5] = '{16'h2234, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
        logic             ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic             eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = ta[v]; in_b = tb[v]; in_cin = tc[v]; in_sub = tsb[v];
            @(posedge clk); #1;
            drive_idle();
            for (int n = 0; n <= NBLK + 1; n++) begin
                if (n > 0) begin @(posedge clk); #1; end
                checks++;
                if (out_valid !== (n == NBLK)) begin
                    failures++;
                    $display("FAIL dir%0d_valid_edge%0d got=%b exp=%b", v, n, out_valid, (n == NBLK));
                end
                if (n == NBLK) begin
                    checks++; if (out_sum !== es[v]) begin failures++; $display("FAIL dir%0d_sum got=%h exp=%h", v, out_sum, es[v]); end
                    checks++; if (out_cout !== ec[v]) begin failures++; $display("FAIL dir%0d_cout got=%b exp=%b", v, out_cout, ec[v]); end
                    checks++; if (out_ovf !== eo[v]) begin failures++; $display("FAIL dir%0d_ovf got=%b exp=%b", v, out_ovf, eo[v]); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            drive_rand();
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_%0d got=%b exp=1", i, in_ready); end
        end
        @(posedge clk); #1;
        drive_idle();
        for (int t = 0; t < 30 && got_q.size() < 8; t++) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=8 (model=%0d)", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_result_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
                checks++; if (got_t[i] != got_t[0] + i) begin failures++; $display("FAIL b2b_gap_%0d got_cycle=%0d exp_cycle=%0d", i, got_t[i], got_t[0] + i); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] snap;
        clear_sb();
        snap = '0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            out_ready = !(i >= 6 && i <= 8);
            if (i < 10) drive_rand(); else drive_idle();
            #1;
            if (i == 6) snap = {out_cout, out_ovf, out_sum};
            if (i >= 6 && i <= 8) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_%0d got=%b exp=0", i, in_ready); end
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_%0d got=%b exp=1", i, out_valid); end
            end
            if (i >= 7 && i <= 9) begin
                checks++;
                if ({out_cout, out_ovf, out_sum} !== snap) begin
                    failures++;
                    $display("FAIL bp_hold_%0d got=%h exp=%h", i, {out_cout, out_ovf, out_sum}, snap);
                end
            end
        end
        out_ready = 1'b1;
        for (int t = 0; t < 30 && (got_q.size() < exp_q.size() || out_valid); t++) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_result_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_random();
        int errs;
        clear_sb();
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) drive_rand(); else drive_idle();
        end
        @(posedge clk); #1;
        drive_idle();
        out_ready = 1'b1;
        for (int t = 0; t < 40 && (got_q.size() < exp_q.size() || out_valid); t++) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_result_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0] e;
        clear_sb();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive_rand();
        end
        @(posedge clk); #1;
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_sum !== '0) begin failures++; $display("FAIL mid_rst_sum got=%h exp=0000", out_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_sb();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_%0d got=%b exp=0", i, out_valid); end
        end
        drive_rand();
        e = model(in_a, in_b, in_cin, in_sub);
        @(posedge clk); #1;
        drive_idle();
        for (int n = 0; n <= NBLK + 1; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            checks++;
            if (out_valid !== (n == NBLK)) begin
                failures++;
                $display("FAIL mid_new_valid_edge%0d got=%b exp=%b", n, out_valid, (n == NBLK));
            end
            if (n == NBLK) begin
                checks++;
                if ({out_cout, out_ovf, out_sum} !== e) begin
                    failures++;
                    $display("FAIL mid_new_result got=%h exp=%h", {out_cout, out_ovf, out_sum}, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csel_adder_pipe.md
Name: csel_adder_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit carry-select adder.
- Operand width WIDTH is split into NBLK = WIDTH/BLK carry-select blocks.
  - Each block precomputes sum/carry for carry-in 0 and 1.
  - One block per pipeline stage resolves its mux using the registered carry from the previous stage.
- Adds a subtract mode, signed-overflow and carry flags, and a valid/ready handshake with global stall.
- Sits between operand-issue logic and any consumer needing a registered WIDTH-bit add/sub result.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of BLK and at least BLK.
- BLK, 4, bits per carry-select block; each block is one pipeline stage.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand bundle valid.
- in_ready, output, 1, block can accept a bundle this cycle.
- in_a, input, WIDTH, operand A.
- in_b, input, WIDTH, operand B.
- in_cin, input, 1, carry-in; ignored when in_sub=1.
- in_sub, input, 1, 0 = A+B+cin, 1 = A-B (A + ~B + 1).
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- out_sum, output, WIDTH, result.
- out_cout, output, 1, carry-out of MSB block; for subtract, 1 = no borrow.
- out_ovf, output, 1, two's-complement overflow.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All stage valid bits and out_valid go to 0.
  - out_sum, out_cout, out_ovf go to 0; all stage data registers go to 0.
  - in_ready reads 1 once reset is released.
  - Reset mid-operation discards every in-flight bundle; no partial result is ever presented.
- Stall condition: stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - While stall=1, every stage register holds, including out_*, which must stay stable.
- Accept: the bundle is captured when in_valid & in_ready at a rising edge. On capture:
  - Effective B is latched as in_b ^ {WIDTH{in_sub}}.
  - Effective carry-in is latched as in_sub ? 1 : in_cin.
- Pipeline: stage k (k = 0..NBLK-1) holds the full operands, the resolved sum bits [k*BLK-1:0], and the carry into block k.
  - Stage k computes block k with the sub-module (carry-in 0 and carry-in 1 variants).
  - It selects the variant using its registered carry and passes resolved bits plus block carry-out to stage k+1.
  - Operand bits already consumed may be dropped.
- Latency: a bundle accepted at edge E appears on out_* with out_valid=1 after edge E+NBLK, absent stalls.
  - Each stall cycle adds exactly one cycle.
  - Throughput is one bundle per cycle; back-to-back accepts yield back-to-back results in order.
- Flags:
  - out_cout = carry-out of block NBLK-1.
  - out_ovf = carry into MSB XOR carry out of MSB, computed inside the last block from its ripple chain.
- Output handshake: the result retires at an edge with out_valid & out_ready. A new result may load in the same edge, so there are no bubbles when out_ready is held high.
- Degenerate case WIDTH=BLK: NBLK=1, latency 1.
- Bubbles: stage valid bits propagate without stalling the pipe. Bubbles never stall upstream; only out_valid & ~out_ready stalls.
- Width rules:
  - All arithmetic is modulo 2^WIDTH; no sign extension.
  - X on in_a/in_b while in_valid=0 must not propagate into any valid output.

Decomposition:
- No shared package required. NBLK is a localparam derived in the module.
- The op encoding (ADD=0, SUB=1) goes in the team's arith package as a named constant if that package exists.
- One sub-module, csel_block (parameter BLK):
  - Inputs: a, b, cin. Outputs: sum, cout, c_msb_in (carry into the MSB, used for overflow).
  - Internally two BLK-bit ripple chains plus a 2:1 select; purely combinational.
- The top level generates NBLK instances and the stage registers.

Test Plan:
- WIDTH=16, BLK=4, out_ready=1: A=0x1234, B=0x0FFF, cin=1, sub=0 -> after 4 edges sum=0x2234, cout=0, ovf=0, out_valid for exactly 1 cycle.
- Carry propagates across all blocks: A=0xFFFF, B=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0; A=0x7FFF, B=0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0.
- Subtract: A=0x0005, B=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0; A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, ovf=1, cout=1.
- Back-to-back: 8 consecutive bundles with random operands -> 8 consecutive valid results in order matching the model; in_ready stays 1 throughout.
- Backpressure: with results pending, drop out_ready for 3 cycles -> in_ready=0, out_* stable for 3 cycles; raise out_ready -> no loss or duplication, order preserved.
- Reset mid-flight: assert rst_n=0 asynchronously with 3 bundles in flight -> out_valid=0, out_sum=0 immediately; after release, no stale results and the first new bundle returns after 4 edges.
